// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
// Half-period arithmetic lives here so tops and benches derive it the same way.
package clkdiv_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 50_000_000;
    localparam int unsigned DIV_W          = 32;

    typedef logic [DIV_W-1:0] div_t;

    function automatic div_t half_from_freq(input int unsigned clk_hz, input int unsigned freq);
        return div_t'(clk_hz / (2 * freq));
    endfunction

endpackage

// File: rtl/multi_clock_divider_if.sv
// Configuration request/accept channel for multi_clock_divider.
// The requester holds valid/ch/div stable until valid && ready.
interface multi_clock_divider_if #(
    parameter int unsigned CH_W  = 2,
    parameter int unsigned CNT_W = 32
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_err;

    modport master (
        output cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, cfg_err
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, cfg_err
    );
endinterface

// File: rtl/clkdiv_channel.sv
// One divided-clock channel: counter, active/next half-period, toggle and rise strobe.
// A pending half-period is only swapped in at a falling edge, on sync, or while disabled.
module clkdiv_channel #(
    parameter int unsigned      CNT_W        = 32,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(520)
) (
    input  logic             clk_50MHz,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_sync,
    input  logic             i_wr,
    input  logic [CNT_W-1:0] i_wr_div,
    output logic             o_pending,
    output logic             o_clk,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_half;
    logic [CNT_W-1:0] r_next_half;
    logic             r_pending;
    logic             r_clk;
    logic             r_tick;
    logic             w_wrap;

    assign w_wrap = (r_cnt == (r_half - CNT_W'(1)));

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_half      <= DEFAULT_HALF;
            r_next_half <= DEFAULT_HALF;
            r_pending   <= 1'b0;
            r_clk       <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            if (!i_en || i_sync) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                if (r_pending) begin
                    r_half    <= r_next_half;
                    r_pending <= 1'b0;
                end
            end else if (w_wrap) begin
                r_cnt  <= '0;
                r_clk  <= ~r_clk;
                r_tick <= ~r_clk;
                if (r_clk && r_pending) begin
                    r_half    <= r_next_half;
                    r_pending <= 1'b0;
                end
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_tick <= 1'b0;
            end
            // A write is only accepted while nothing is pending, so it never races an apply
            if (i_wr) begin
                r_next_half <= i_wr_div;
                r_pending   <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;
    assign o_clk     = r_clk;
    assign o_tick    = r_tick;

endmodule

// File: rtl/multi_clock_divider.sv
// NUM_CH independent programmable clock dividers off clk_50MHz with rise strobes.
// The top only decodes configuration requests and muxes per-channel readiness.
module multi_clock_divider
    import clkdiv_pkg::*;
#(
    parameter int unsigned CLK_HZ       = DEFAULT_CLK_HZ,
    parameter int unsigned DEFAULT_FREQ = 48_000,
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                 clk_50MHz,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    ch_en,
    input  logic                 sync_restart,
    multi_clock_divider_if.slave cfg,
    output logic [NUM_CH-1:0]    clk_out,
    output logic [NUM_CH-1:0]    tick
);

    localparam logic [CNT_W-1:0] DEFAULT_HALF = CNT_W'(half_from_freq(CLK_HZ, DEFAULT_FREQ));
    localparam logic [CH_W:0]    LP_NUM_CH    = (CH_W + 1)'(NUM_CH);

    logic [NUM_CH-1:0] w_pending;
    logic [NUM_CH-1:0] w_wr;
    logic              w_ch_ok;
    logic              w_div_ok;
    logic              w_legal;
    logic              w_pend_sel;
    logic              w_xfer;
    logic              r_err;

    assign w_ch_ok  = ({1'b0, cfg.cfg_ch} < LP_NUM_CH);
    assign w_div_ok = (cfg.cfg_div != '0);
    assign w_legal  = w_ch_ok && w_div_ok;

    always_comb begin
        w_pend_sel = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                w_pend_sel = w_pending[i];
            end
        end
    end

    // Illegal requests are always accepted so the requester never stalls on them
    assign cfg.cfg_ready = !w_legal || !w_pend_sel;
    assign w_xfer        = cfg.cfg_valid && cfg.cfg_ready;

    always_comb begin
        w_wr = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            w_wr[i] = w_xfer && w_legal && (cfg.cfg_ch == CH_W'(i));
        end
    end

    always_ff @(posedge clk_50MHz or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_xfer && !w_legal;
        end
    end

    assign cfg.cfg_err = r_err;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clkdiv_channel #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk_50MHz (clk_50MHz),
            .rst       (rst),
            .i_en      (ch_en[g]),
            .i_sync    (sync_restart),
            .i_wr      (w_wr[g]),
            .i_wr_div  (cfg.cfg_div),
            .o_pending (w_pending[g]),
            .o_clk     (clk_out[g]),
            .o_tick    (tick[g])
        );
    end

endmodule

// File: tb/tb_multi_clock_divider.sv
// Directed bench for multi_clock_divider: reset, periods, reconfig, errors, sync, enable, reset.
// CH_W is widened to 3 so an out-of-range channel number can be presented.
module tb_multi_clock_divider;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned CH_W   = 3;
    localparam int unsigned CNT_W  = 32;

    logic              clk_50MHz = 1'b0;
    logic              rst;
    logic [NUM_CH-1:0] ch_en;
    logic              sync_restart;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned c;

    multi_clock_divider_if #(.CH_W(CH_W), .CNT_W(CNT_W)) cfg_if ();

    multi_clock_divider #(
        .CLK_HZ       (50_000_000),
        .DEFAULT_FREQ (48_000),
        .NUM_CH       (NUM_CH),
        .CNT_W        (CNT_W),
        .CH_W         (CH_W)
    ) dut (
        .clk_50MHz    (clk_50MHz),
        .rst          (rst),
        .ch_en        (ch_en),
        .sync_restart (sync_restart),
        .cfg          (cfg_if),
        .clk_out      (clk_out),
        .tick         (tick)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(posedge clk_50MHz);
            #1;
        end
    endtask

    // Edges until clk_out[ch] reaches val, capped so a dead channel cannot hang the run
    task automatic wait_clk(input logic [1:0] ch, input logic val, output int unsigned cyc);
        cyc = 0;
        do begin
            step(1);
            cyc++;
        end while (clk_out[ch] !== val && cyc < 5000);
    endtask

    initial begin
        rst                = 1'b1;
        ch_en              = '0;
        sync_restart       = 1'b0;
        cfg_if.cfg_valid   = 1'b0;
        cfg_if.cfg_ch      = '0;
        cfg_if.cfg_div     = '0;

        step(3);
        check("rst_clk_out", 32'(clk_out), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_err", 32'(cfg_if.cfg_err), 32'd0);
        check("rst_ready", 32'(cfg_if.cfg_ready), 32'd1);
        rst = 1'b0;
        step(2);

        // Default 520-cycle half period on ch0
        ch_en = 4'b0001;
        wait_clk(2'd0, 1'b1, c);
        check("ch0_first_rise", c, 32'd520);
        check("ch0_rise_tick", 32'(tick), 32'b0001);
        check("ch0_only", 32'(clk_out), 32'b0001);
        step(1);
        check("ch0_tick_1cyc", 32'(tick), 32'd0);
        wait_clk(2'd0, 1'b0, c);
        check("ch0_high_len", c, 32'd519);
        wait_clk(2'd0, 1'b1, c);
        check("ch0_low_len", c, 32'd520);
        check("ch0_tick_again", 32'(tick), 32'b0001);

        // Reprogram ch1 to half=3 mid high-phase; old period finishes first
        ch_en = 4'b0011;
        wait_clk(2'd1, 1'b1, c);
        check("ch1_first_rise", c, 32'd520);
        step(300);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd1;
        cfg_if.cfg_div   = 32'd3;
        #1;
        check("ch1_ready_before", 32'(cfg_if.cfg_ready), 32'd1);
        step(1);
        cfg_if.cfg_valid = 1'b0;
        #1;
        check("ch1_ready_pending", 32'(cfg_if.cfg_ready), 32'd0);
        wait_clk(2'd1, 1'b0, c);
        check("ch1_old_high_done", c, 32'd219);
        check("ch1_ready_applied", 32'(cfg_if.cfg_ready), 32'd1);
        wait_clk(2'd1, 1'b1, c);
        check("ch1_new_low", c, 32'd3);
        check("ch1_new_tick", 32'(tick[1]), 32'd1);
        wait_clk(2'd1, 1'b0, c);
        check("ch1_new_high", c, 32'd3);
        wait_clk(2'd1, 1'b1, c);
        check("ch1_new_low2", c, 32'd3);

        // Illegal requests: zero divider, then channel out of range
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd2;
        cfg_if.cfg_div   = 32'd0;
        #1;
        check("div0_ready", 32'(cfg_if.cfg_ready), 32'd1);
        step(1);
        check("div0_err", 32'(cfg_if.cfg_err), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        step(1);
        check("div0_err_1cyc", 32'(cfg_if.cfg_err), 32'd0);
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd5;
        cfg_if.cfg_div   = 32'd7;
        #1;
        check("ch5_ready", 32'(cfg_if.cfg_ready), 32'd1);
        step(1);
        check("ch5_err", 32'(cfg_if.cfg_err), 32'd1);
        cfg_if.cfg_valid = 1'b0;
        step(1);
        check("ch5_err_1cyc", 32'(cfg_if.cfg_err), 32'd0);

        // Disabled channel applies on the next edge; half=1 is the fastest output
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd3;
        cfg_if.cfg_div   = 32'd1;
        step(1);
        cfg_if.cfg_valid = 1'b0;
        #1;
        check("ch3_pending", 32'(cfg_if.cfg_ready), 32'd0);
        step(1);
        check("ch3_applied_idle", 32'(cfg_if.cfg_ready), 32'd1);
        ch_en = 4'b1011;
        wait_clk(2'd3, 1'b1, c);
        check("ch3_half1_rise", c, 32'd1);
        wait_clk(2'd3, 1'b0, c);
        check("ch3_half1_fall", c, 32'd1);
        ch_en = 4'b0011;

        // sync_restart applies ch1's fresh half=260 and realigns all channels
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd1;
        cfg_if.cfg_div   = 32'd260;
        step(1);
        cfg_if.cfg_valid = 1'b0;
        ch_en            = 4'b0111;
        sync_restart     = 1'b1;
        step(1);
        sync_restart = 1'b0;
        check("sync_clk_low", 32'(clk_out), 32'd0);
        check("sync_tick_low", 32'(tick), 32'd0);
        wait_clk(2'd1, 1'b1, c);
        check("sync_ch1_rise", c, 32'd260);
        check("sync_ch1_pattern", 32'(clk_out), 32'b0010);
        wait_clk(2'd0, 1'b1, c);
        check("sync_ch0_rise", c, 32'd260);
        check("sync_ch02_pattern", 32'(clk_out), 32'b0101);
        check("sync_ch02_tick", 32'(tick), 32'b0101);

        // Enable drop truncates immediately; re-enable waits a full half
        step(100);
        ch_en = 4'b0110;
        step(1);
        check("drop_ch0_low", 32'(clk_out[0]), 32'd0);
        step(5);
        check("drop_ch0_stays", 32'(clk_out[0]), 32'd0);
        ch_en = 4'b0111;
        wait_clk(2'd0, 1'b1, c);
        check("reen_ch0_rise", c, 32'd520);

        // Reset mid-period discards a pending write
        cfg_if.cfg_valid = 1'b1;
        cfg_if.cfg_ch    = 3'd0;
        cfg_if.cfg_div   = 32'd10;
        step(1);
        cfg_if.cfg_valid = 1'b0;
        #1;
        check("rst_pend_set", 32'(cfg_if.cfg_ready), 32'd0);
        step(50);
        rst = 1'b1;
        #1;
        check("rst_async_clk", 32'(clk_out), 32'd0);
        check("rst_pend_clear", 32'(cfg_if.cfg_ready), 32'd1);
        ch_en = 4'b0001;
        step(2);
        rst = 1'b0;
        wait_clk(2'd0, 1'b1, c);
        check("post_rst_rise", c, 32'd520);
        wait_clk(2'd0, 1'b0, c);
        check("post_rst_high", c, 32'd520);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
